// File: rtl/cdb_pkg.sv
// Shared CDB definitions: broadcast packet type, default widths and index helpers.
// The reorder buffer and reservation stations import the same widths.
package cdb_pkg;

    localparam int unsigned CDB_XLEN      = 32;
    localparam int unsigned CDB_TAG_WIDTH = 8;

    typedef struct packed {
        logic                     active;
        logic [CDB_XLEN-1:0]      data;
        logic [CDB_TAG_WIDTH-1:0] tag;
    } cdb_packet_t;

    // (a + b) mod n, valid while a < n and b < n; keeps non-power-of-2 counts in range
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned a, input int unsigned n);
        return wrap_add(a, 1, n);
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side handshake and CDB broadcast bundle for the CDB arbiter.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned XLEN      = CDB_XLEN,
    parameter int unsigned TAG_WIDTH = CDB_TAG_WIDTH
) ();

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0][XLEN-1:0]      req_data;
    logic [N_REQ-1:0][TAG_WIDTH-1:0] req_tag;
    logic [N_REQ-1:0]                req_ready;
    logic                            flush;
    logic                            cdb_active;
    logic [XLEN-1:0]                 cdb_data;
    logic [TAG_WIDTH-1:0]            cdb_tag;

    modport master (
        output req_valid, req_data, req_tag, flush,
        input  req_ready, cdb_active, cdb_data, cdb_tag
    );

    modport slave (
        input  req_valid, req_data, req_tag, flush,
        output req_ready, cdb_active, cdb_data, cdb_tag
    );

endinterface

// File: rtl/rr_priority_select.sv
// Round-robin first-one select: rotate requests so i_ptr is position 0, find the
// lowest set bit, then map the offset back to an absolute index.
module rr_priority_select
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [PTR_W-1:0] o_winner,
    output logic             o_valid
);

    logic [N_REQ-1:0] w_rot;
    logic [PTR_W-1:0] w_off;

    always_comb begin
        w_rot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_rot[i] = i_req[PTR_W'(wrap_add(int'(i_ptr), i, N_REQ))];
        end
    end

    // Descending scan so the lowest set offset is the last one written
    always_comb begin
        w_off = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PTR_W'(i);
            end
        end
    end

    always_comb begin
        o_valid  = |w_rot;
        o_winner = PTR_W'(wrap_add(int'(i_ptr), int'(w_off), N_REQ));
        o_grant  = '0;
        if (o_valid) begin
            o_grant[o_winner] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: one registered broadcast per cycle,
// suppressed on flush.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned XLEN      = CDB_XLEN,
    parameter int unsigned TAG_WIDTH = CDB_TAG_WIDTH,
    parameter int unsigned PTR_W     = $clog2(N_REQ)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    cdb_arbiter_if.slave  io_bus
);

    logic [N_REQ-1:0] w_grant;
    logic [PTR_W-1:0] w_winner;
    logic             w_any;
    logic             w_xfer;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    cdb_packet_t      r_cdb;
    cdb_packet_t      w_cdb_next;

    rr_priority_select #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_select (
        .i_req    (io_bus.req_valid),
        .i_ptr    (r_ptr),
        .o_grant  (w_grant),
        .o_winner (w_winner),
        .o_valid  (w_any)
    );

    // Grant never waits on consumers; only flush or reset can withhold it
    assign io_bus.req_ready = (i_rst_n && !io_bus.flush) ? w_grant : '0;
    assign w_xfer           = w_any && i_rst_n && !io_bus.flush;

    always_comb begin
        w_ptr_next        = r_ptr;
        w_cdb_next        = r_cdb;
        w_cdb_next.active = 1'b0;
        if (w_xfer) begin
            w_ptr_next        = PTR_W'(wrap_inc(int'(w_winner), N_REQ));
            w_cdb_next.active = 1'b1;
            w_cdb_next.data   = io_bus.req_data[w_winner];
            w_cdb_next.tag    = io_bus.req_tag[w_winner];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
            r_cdb <= '0;
        end else begin
            r_ptr <= w_ptr_next;
            r_cdb <= w_cdb_next;
        end
    end

    assign io_bus.cdb_active = r_cdb.active;
    assign io_bus.cdb_data   = r_cdb.data;
    assign io_bus.cdb_tag    = r_cdb.tag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with N_REQ=4: vector table plus hand-written
// sequences for reset-state, single request and asynchronous mid-run reset.
module tb_cdb_arbiter;

    localparam int unsigned N = 4;

    typedef struct {
        logic [3:0] valid;
        logic       flush;
        logic [3:0] exp_ready;
        logic       exp_active;
        int         exp_unit;   // unit whose tag/data must be on the bus after the edge
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .XLEN(32), .TAG_WIDTH(8)) bus ();

    cdb_arbiter #(.N_REQ(N), .XLEN(32), .TAG_WIDTH(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  tag_a  [N];
    logic [31:0] data_a [N];
    vec_t        vecs   [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic f);
        bus.req_valid = v;
        bus.flush     = f;
        for (int i = 0; i < int'(N); i++) begin
            bus.req_data[i] = data_a[i];
            bus.req_tag[i]  = tag_a[i];
        end
    endtask

    task automatic chk_bus(input string nm, input logic act, input int unit);
        chk({nm, " active"}, {31'd0, bus.cdb_active}, {31'd0, act});
        chk({nm, " tag"}, {24'd0, bus.cdb_tag}, {24'd0, tag_a[unit]});
        chk({nm, " data"}, bus.cdb_data, data_a[unit]);
    endtask

    task automatic default_units();
        tag_a  = '{8'h2A, 8'h31, 8'h42, 8'h53};
        data_a = '{32'h1111_AAAA, 32'h2222_BBBB, 32'h3333_CCCC, 32'h4444_DDDD};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge: drive, check comb grant, check registered bus after the edge
    task automatic apply(input vec_t v, input int idx);
        drive(v.valid, v.flush);
        #1;
        chk($sformatf("v%0d ready", idx), {28'd0, bus.req_ready}, {28'd0, v.exp_ready});
        @(posedge clk);
        #1;
        chk_bus($sformatf("v%0d bus", idx), v.exp_active, v.exp_unit);
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 0};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 1'b1, 2};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 1'b1, 3};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 1'b1, 0};
        vecs[5]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2};
        vecs[6]  = '{4'b0110, 1'b0, 4'b0010, 1'b1, 1};  // ptr=3, wraps to unit 1
        vecs[7]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2};
        vecs[8]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2};  // flush: hold unit 2 payload
        vecs[9]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};  // idle: tag 0x2A held
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 0};
        vecs[13] = '{4'b1111, 1'b0, 4'b0010, 1'b1, 1};  // ptr still 1 after idles
        vecs[14] = '{4'b1111, 1'b1, 4'b0000, 1'b0, 1};
        vecs[15] = '{4'b1011, 1'b0, 4'b1000, 1'b1, 3};  // ptr 2 kept through flush

        // Reset state, with a request already pending
        default_units();
        tag_a[2]  = 8'h05;
        data_a[2] = 32'hDEAD_BEEF;
        drive(4'b0100, 1'b0);
        #1;
        chk("reset ready", {28'd0, bus.req_ready}, 32'd0);
        chk("reset active", {31'd0, bus.cdb_active}, 32'd0);
        chk("reset data", bus.cdb_data, 32'd0);
        chk("reset tag", {24'd0, bus.cdb_tag}, 32'd0);

        // Single request from unit 2
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("single ready", {28'd0, bus.req_ready}, 32'b0100);
        @(posedge clk);
        #1;
        chk_bus("single bus", 1'b1, 2);
        @(negedge clk);
        drive(4'b1001, 1'b0);
        #1;
        chk("single ptr3 ready", {28'd0, bus.req_ready}, 32'b1000);

        // Table run from a fresh reset
        default_units();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], i);
        end

        // Asynchronous reset between edges while a broadcast is live
        drive(4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async active", {31'd0, bus.cdb_active}, 32'd0);
        chk("async data", bus.cdb_data, 32'd0);
        chk("async tag", {24'd0, bus.cdb_tag}, 32'd0);
        chk("async ready", {28'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post-reset ready", {28'd0, bus.req_ready}, 32'b0001);
        @(posedge clk);
        #1;
        chk_bus("post-reset bus", 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
